// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared definitions for the data-memory bus controller: opcodes (must match
// the load/store formatting stage), FSM state encoding and opcode decode helpers.
package dmem_bus_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'd0;
    localparam logic [5:0] OP_LH  = 6'd1;
    localparam logic [5:0] OP_LW  = 6'd2;
    localparam logic [5:0] OP_LBU = 6'd3;
    localparam logic [5:0] OP_LHU = 6'd4;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_valid_op(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic size_t op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            default:              return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bus_ctrl_lane_align.sv
// Byte-lane steering: lane enables and store-data shift toward the bus,
// right alignment of the read word back toward the core.
module dmem_lane_align
    import dmem_bus_ctrl_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_al
);

    always_comb begin
        be = '0;
        case (size)
            SZ_B:    be = 4'b0001 << offset;
            SZ_H:    be = 4'b0011 << offset;
            default: be = 4'b1111;
        endcase
    end

    assign wdata_sh = wdata << {offset, 3'b000};
    assign rdata_al = rdata >> {offset, 3'b000};

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns one load/store request into a single
// word-aligned valid/ack bus transaction, stalling the core until it completes.
module dmem_bus_ctrl
    import dmem_bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [5:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              fault_misalign,
    output logic              fault_timeout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    state_t            state, state_nx;
    logic [5:0]        op_q;
    logic [ADDR_W-3:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        off_q;
    logic [7:0]        cnt_q;
    logic [31:0]       rdata_al;
    logic              accept;
    logic              misalign;
    logic              timeout_hit;
    size_t             req_size;

    assign req_size    = op_size(req_op);
    assign accept      = (state == ST_IDLE) && req_valid && is_valid_op(req_op);
    assign misalign    = ((req_size == SZ_H) && req_addr[0]) ||
                         ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

    assign mem_addr = {waddr_q, 2'b00};
    assign mem_we   = is_store(op_q);

    dmem_lane_align u_align (
        .size     (op_size(op_q)),
        .offset   (off_q),
        .wdata    (wdata_q),
        .rdata    (mem_rdata),
        .be       (mem_be),
        .wdata_sh (mem_wdata),
        .rdata_al (rdata_al)
    );

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        mem_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    stall    = 1'b1;
                    state_nx = misalign ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                // ack takes priority over an expiring counter
                if (mem_ack || timeout_hit)
                    state_nx = ST_RESP;
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            op_q           <= '0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            off_q          <= '0;
            cnt_q          <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            fault_misalign <= 1'b0;
            fault_timeout  <= 1'b0;
        end else begin
            state          <= state_nx;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            fault_misalign <= 1'b0;
            fault_timeout  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= req_op;
                        waddr_q <= req_addr[ADDR_W-1:2];
                        wdata_q <= req_wdata;
                        off_q   <= req_addr[1:0];
                        cnt_q   <= '0;
                        if (misalign) begin
                            rsp_valid      <= 1'b1;
                            fault_misalign <= 1'b1;
                        end
                    end
                end
                ST_BUS: begin
                    if (mem_ack) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= is_load(op_q) ? rdata_al : '0;
                    end else if (timeout_hit) begin
                        rsp_valid     <= 1'b1;
                        fault_timeout <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Randomized self-checking bench for dmem_bus_ctrl against a transaction-level model.
module tb_dmem_bus_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        fault_misalign;
    logic        fault_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    dmem_bus_ctrl #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .fault_misalign (fault_misalign),
        .fault_timeout  (fault_timeout),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [5:0] op);
        case (op)
            6'd0, 6'd3, 6'd15: return 1;
            6'd1, 6'd4, 6'd16: return 2;
            default:           return 4;
        endcase
    endfunction

    // delay = number of BUS cycles without ack before the ack; >= TMO means never
    task automatic txn(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input int delay);
        int          bytes   = nbytes(op);
        int          off     = int'(addr % 4);
        bit          st      = (op >= 6'd15);
        bit          mis     = (addr % bytes) != 0;
        bit          tmo     = !mis && (delay >= TMO);
        int          exp_bus = mis ? 0 : (tmo ? TMO : delay + 1);
        logic [3:0]  exp_be  = 4'(((1 << bytes) - 1) << off);
        logic [31:0] exp_wd  = wd << (8 * off);
        logic [31:0] exp_rd;
        logic [31:0] ack_data = '0;
        int          bus_idx = 0;
        int          n_stall = 0;
        bit          spurious = 0;
        bit          got = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
                req_valid = 1'b1;
                req_op    = op;
                req_addr  = addr;
                req_wdata = wd;
            end
            mem_rdata = $urandom;
            if (mem_req) begin
                mem_ack = (bus_idx == delay);
                if (bus_idx == delay) ack_data = mem_rdata;
                bus_idx++;
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            #1;
            if (stall) n_stall++;
            if (mem_req) begin
                chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
                chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
                chk("mem_wdata", mem_wdata, exp_wd);
                chk("mem_we", {31'd0, mem_we}, {31'd0, st});
            end
            if (!rsp_valid && (fault_misalign || fault_timeout)) spurious = 1;
            if (rsp_valid) begin
                exp_rd = (!mis && !tmo && !st) ? (ack_data >> (8 * off)) : 32'd0;
                got = 1;
                chk("rsp_cycle", cyc, exp_bus + 1);
                chk("stall_cycles", n_stall, exp_bus + 1);
                chk("bus_cycles", bus_idx, exp_bus);
                chk("stall_in_resp", {31'd0, stall}, 32'd0);
                chk("rsp_rdata", rsp_rdata, exp_rd);
                chk("fault_misalign", {31'd0, fault_misalign}, {31'd0, mis});
                chk("fault_timeout", {31'd0, fault_timeout}, {31'd0, tmo});
                chk("spurious_fault", {31'd0, spurious}, 32'd0);
                break;
            end
        end
        if (!got) chk("rsp_bound", 32'd0, 32'd1);
        mem_ack = 1'b0;
    endtask

    task automatic gap(input bit bad_op);
        @(posedge clk); #1;
        req_valid = bad_op;
        req_op    = bad_op ? 6'(5 + $urandom_range(0, 9)) : 6'd0;
        mem_ack   = 1'($urandom_range(0, 1));
        #1;
        chk("ignored_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        #1;
        chk("ignored_mem_req", {31'd0, mem_req}, 32'd0);
        chk("ignored_rsp", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [5:0]  ops [8] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd15, 6'd16, 6'd17};
        logic [5:0]  op;
        logic [31:0] wd;
        int          r;

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0;
        req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        #3;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_faults", {30'd0, fault_misalign, fault_timeout}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        txn(6'd17, 32'h104, 32'hDEADBEEF, 0);
        txn(6'd0,  32'h203, 32'h0, 0);
        txn(6'd1,  32'h201, 32'h0, 0);
        txn(6'd16, 32'h302, 32'h0000BEEF, 5);
        txn(6'd2,  32'h400, 32'h0, 1000);
        txn(6'd2,  32'h404, 32'h0, TMO - 1);
        gap(1'b1);
        gap(1'b0);

        // reset mid-transaction, in the 2nd BUS cycle
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 6'd2; req_addr = 32'h500; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("async_rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("late_ack_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;

        for (int n = 0; n < 120; n++) begin
            op = ops[$urandom_range(0, 7)];
            wd = $urandom;
            if (nbytes(op) == 1) wd = wd & 32'h0000_00FF;
            else if (nbytes(op) == 2) wd = wd & 32'h0000_FFFF;
            r = $urandom_range(0, 10);
            txn(op, $urandom, wd, (r == 10) ? 1000 : r);
            if ($urandom_range(0, 5) == 0) gap(1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
